// File: rtl/pwm_pkg.sv
// Shared definitions for the dual-channel H-bridge PWM peripheral:
// register offsets, bridge FSM state encoding and the duty magnitude helper.
package pwm_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_PERIOD = 4'h4;
    localparam logic [3:0] ADDR_DUTY1  = 4'h8;
    localparam logic [3:0] ADDR_DUTY2  = 4'hC;

    typedef enum logic [1:0] {
        FWD  = 2'b00,
        REV  = 2'b01,
        DEAD = 2'b10
    } bridge_state_t;

    // Absolute value of a sign-extended duty; the most-negative duty of the
    // narrower source format maps cleanly to 2^CNT_W at this width.
    function automatic logic [32:0] duty_mag(input logic [32:0] duty);
        logic [32:0] mag;
        if (duty[32]) begin
            mag = ~duty + 33'd1;
        end else begin
            mag = duty;
        end
        return mag;
    endfunction

endpackage

// File: rtl/pwm_bridge_ch.sv
// One H-bridge channel: duty compare against the shared counter and a
// dead-time FSM that keeps both legs low for DEAD_CYCLES on a direction change.
module pwm_bridge_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             ch_en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W:0]   duty,
    output logic [1:0]       drive
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYCLES - 1);

    logic [32:0]   duty_ext_s;
    logic [32:0]   mag_s;
    logic          on_s;
    logic          neg_s;
    logic          zero_s;
    logic          act_s;
    logic [1:0]    fwd_drv_s;
    logic [1:0]    rev_drv_s;
    bridge_state_t state_r;
    logic [DW-1:0] dead_r;
    logic [1:0]    drive_r;

    assign duty_ext_s = {{(32 - CNT_W){duty[CNT_W]}}, duty};
    assign mag_s      = duty_mag(duty_ext_s);
    assign on_s       = ({{(33 - CNT_W){1'b0}}, cnt} < mag_s);
    assign neg_s      = duty[CNT_W];
    assign zero_s     = (duty == {(CNT_W + 1){1'b0}});
    assign act_s      = run & ch_en;
    assign fwd_drv_s  = {1'b0, on_s & act_s};
    assign rev_drv_s  = {on_s & act_s, 1'b0};

    // Direction FSM with registered drive; a zero duty never forces a direction change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FWD;
            dead_r  <= {DW{1'b0}};
            drive_r <= 2'b00;
        end else begin
            case (state_r)
                FWD: begin
                    if (neg_s) begin
                        state_r <= DEAD;
                        dead_r  <= DEAD_INIT;
                        drive_r <= 2'b00;
                    end else begin
                        drive_r <= fwd_drv_s;
                    end
                end
                REV: begin
                    if (!neg_s && !zero_s) begin
                        state_r <= DEAD;
                        dead_r  <= DEAD_INIT;
                        drive_r <= 2'b00;
                    end else begin
                        drive_r <= rev_drv_s;
                    end
                end
                DEAD: begin
                    if (dead_r == {DW{1'b0}}) begin
                        if (neg_s) begin
                            state_r <= REV;
                            drive_r <= rev_drv_s;
                        end else begin
                            state_r <= FWD;
                            drive_r <= fwd_drv_s;
                        end
                    end else begin
                        dead_r  <= dead_r - DW'(1);
                        drive_r <= 2'b00;
                    end
                end
                default: begin
                    state_r <= DEAD;
                    dead_r  <= DEAD_INIT;
                    drive_r <= 2'b00;
                end
            endcase
        end
    end

    assign drive = drive_r;

endmodule

// File: rtl/pwm_hbridge_periph.sv
// Memory-mapped dual-channel H-bridge PWM: bus registers, shared period counter
// and double-buffered period/duty loaded at each period boundary.
module pwm_hbridge_periph
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEAD_CYCLES = 4,
    parameter int RST_PERIOD  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  pwm1out,
    output logic [1:0]  pwm2out
);

    localparam logic [CNT_W-1:0] RST_P    = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   DUTY_ZERO = {(CNT_W + 1){1'b0}};

    logic [1:0]       ctrl_r;
    logic [CNT_W-1:0] period_sh_r;
    logic [CNT_W-1:0] period_act_r;
    logic [CNT_W:0]   duty1_sh_r;
    logic [CNT_W:0]   duty1_act_r;
    logic [CNT_W:0]   duty2_sh_r;
    logic [CNT_W:0]   duty2_act_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      rdata_r;

    logic [CNT_W-1:0] period_sh_nx_s;
    logic [CNT_W:0]   duty1_sh_nx_s;
    logic [CNT_W:0]   duty2_sh_nx_s;
    logic             run_s;
    logic             wrap_s;
    logic             load_s;
    logic [31:0]      rd_mux_s;
    logic             unused_wdata_s;

    assign unused_wdata_s = ^wdata[31:CNT_W+1];

    assign run_s  = en && (period_act_r != CNT_ZERO);
    assign wrap_s = (cnt_r == (period_act_r - CNT_ONE));
    assign load_s = !run_s || wrap_s;

    // Next shadow values so a write on a boundary cycle passes straight to active
    always_comb begin
        period_sh_nx_s = period_sh_r;
        duty1_sh_nx_s  = duty1_sh_r;
        duty2_sh_nx_s  = duty2_sh_r;
        if (we && (addr == ADDR_PERIOD)) begin
            period_sh_nx_s = wdata[CNT_W-1:0];
        end else begin
            period_sh_nx_s = period_sh_r;
        end
        if (we && (addr == ADDR_DUTY1)) begin
            duty1_sh_nx_s = wdata[CNT_W:0];
        end else begin
            duty1_sh_nx_s = duty1_sh_r;
        end
        if (we && (addr == ADDR_DUTY2)) begin
            duty2_sh_nx_s = wdata[CNT_W:0];
        end else begin
            duty2_sh_nx_s = duty2_sh_r;
        end
    end

    // Read mux over shadow values, duty sign-extended
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr)
            ADDR_CTRL:   rd_mux_s = {30'd0, ctrl_r};
            ADDR_PERIOD: rd_mux_s = {{(32 - CNT_W){1'b0}}, period_sh_r};
            ADDR_DUTY1:  rd_mux_s = {{(31 - CNT_W){duty1_sh_r[CNT_W]}}, duty1_sh_r};
            ADDR_DUTY2:  rd_mux_s = {{(31 - CNT_W){duty2_sh_r[CNT_W]}}, duty2_sh_r};
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Control and shadow registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_r      <= 2'b00;
            period_sh_r <= RST_P;
            duty1_sh_r  <= DUTY_ZERO;
            duty2_sh_r  <= DUTY_ZERO;
        end else begin
            if (we && (addr == ADDR_CTRL)) begin
                ctrl_r <= wdata[1:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
            period_sh_r <= period_sh_nx_s;
            duty1_sh_r  <= duty1_sh_nx_s;
            duty2_sh_r  <= duty2_sh_nx_s;
        end
    end

    // Active registers reload at the boundary, or continuously while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_act_r <= RST_P;
            duty1_act_r  <= DUTY_ZERO;
            duty2_act_r  <= DUTY_ZERO;
        end else if (load_s) begin
            period_act_r <= period_sh_nx_s;
            duty1_act_r  <= duty1_sh_nx_s;
            duty2_act_r  <= duty2_sh_nx_s;
        end else begin
            period_act_r <= period_act_r;
            duty1_act_r  <= duty1_act_r;
            duty2_act_r  <= duty2_act_r;
        end
    end

    // Shared period counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (!run_s || wrap_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Registered read data, held between read strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

    pwm_bridge_ch #(
        .CNT_W       (CNT_W),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .run   (run_s),
        .ch_en (ctrl_r[0]),
        .cnt   (cnt_r),
        .duty  (duty1_act_r),
        .drive (pwm1out)
    );

    pwm_bridge_ch #(
        .CNT_W       (CNT_W),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .run   (run_s),
        .ch_en (ctrl_r[1]),
        .cnt   (cnt_r),
        .duty  (duty2_act_r),
        .drive (pwm2out)
    );

endmodule

// File: tb/tb_pwm_hbridge_periph.sv
// Directed bench for pwm_hbridge_periph: register vector table plus
// hand-written PWM, dead-time, enable and reset sequences.
module tb_pwm_hbridge_periph;
    import pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  pwm1out;
    logic [1:0]  pwm2out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          op;   // 0 write, 1 read, 2 idle (rdata must hold)
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    pwm_hbridge_periph dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pwm1out (pwm1out),
        .pwm2out (pwm2out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int op, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
        vecs[nv] = '{op, a, d, e};
        nv++;
    endtask

    // One clock: clear strobes at the falling edge and check both drives
    task automatic step_check(input string name, input int k, input logic [1:0] e1, input logic [1:0] e2);
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        chk({name, "_pwm1"}, k, {30'd0, pwm1out}, {30'd0, e1});
        chk({name, "_pwm2"}, k, {30'd0, pwm2out}, {30'd0, e2});
        chk("overlap1", k, {31'd0, pwm1out[1] & pwm1out[0]}, 32'd0);
        chk("overlap2", k, {31'd0, pwm2out[1] & pwm2out[0]}, 32'd0);
    endtask

    task automatic start_write(input logic [3:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] e);
        re   = 1'b1;
        addr = a;
        @(negedge clk);
        re = 1'b0;
        chk(name, 0, rdata, e);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'd0;

        add(1, ADDR_PERIOD, 32'd0,          32'd1000);
        add(1, ADDR_CTRL,   32'd0,          32'd0);
        add(1, ADDR_DUTY1,  32'd0,          32'd0);
        add(1, ADDR_DUTY2,  32'd0,          32'd0);
        add(0, ADDR_PERIOD, 32'd10,         32'd0);
        add(1, ADDR_PERIOD, 32'd0,          32'd10);
        add(2, 4'h0,        32'd0,          32'd10);
        add(0, ADDR_DUTY1,  32'h0002_0003,  32'd0);
        add(1, ADDR_DUTY1,  32'd0,          32'd3);
        add(0, ADDR_DUTY2,  32'h0001_0000,  32'd0);
        add(1, ADDR_DUTY2,  32'd0,          32'hFFFF_0000);
        add(0, ADDR_DUTY1,  32'hFFFF_FFFB,  32'd0);
        add(1, ADDR_DUTY1,  32'd0,          32'hFFFF_FFFB);
        add(0, 4'h2,        32'hFFFF_FFFF,  32'd0);
        add(1, 4'h2,        32'd0,          32'd0);
        add(0, ADDR_CTRL,   32'hFFFF_FFFF,  32'd0);
        add(1, ADDR_CTRL,   32'd0,          32'd3);
        add(0, ADDR_CTRL,   32'd1,          32'd0);
        add(1, ADDR_CTRL,   32'd0,          32'd1);
        add(0, ADDR_DUTY2,  32'd0,          32'd0);
        add(1, ADDR_DUTY2,  32'd0,          32'd0);
        add(0, ADDR_DUTY1,  32'd3,          32'd0);
        add(1, ADDR_DUTY1,  32'd0,          32'd3);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pwm1", 0, {30'd0, pwm1out}, 32'd0);
        chk("rst_pwm2", 0, {30'd0, pwm2out}, 32'd0);
        chk("rst_rdata", 0, rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Register table, en low so drives stay off
        for (int i = 0; i < nv; i++) begin
            case (vecs[i].op)
                0: begin
                    start_write(vecs[i].a, vecs[i].d);
                    @(negedge clk);
                    we = 1'b0;
                end
                1: begin
                    re   = 1'b1;
                    addr = vecs[i].a;
                    @(negedge clk);
                    re = 1'b0;
                    chk("reg_read", i, rdata, vecs[i].exp);
                end
                default: begin
                    @(negedge clk);
                    chk("reg_hold", i, rdata, vecs[i].exp);
                end
            endcase
            chk("reg_pwm1", i, {30'd0, pwm1out}, 32'd0);
        end

        // Read and write of the same register in one cycle returns the old value
        we = 1'b1; re = 1'b1; addr = ADDR_PERIOD; wdata = 32'd77;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("rw_same_old", 0, rdata, 32'd10);
        rd_check("rw_same_new", ADDR_PERIOD, 32'd77);
        start_write(ADDR_PERIOD, 32'd10);
        for (int i = 0; i < 8; i++) step_check("settle", i, 2'b00, 2'b00);

        // Duty 3 of 10 forward, then flip to -5 mid-period
        en = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            int c;
            logic [1:0] e;
            c = (k - 1) % 10;
            if (k <= 30)      e = (c < 3) ? 2'b01 : 2'b00;
            else if (k <= 34) e = 2'b00;
            else              e = (c < 5) ? 2'b10 : 2'b00;
            step_check("flip", k, e, 2'b00);
            if (k == 23) start_write(ADDR_DUTY1, 32'hFFFF_FFFB);
        end

        // Disable mid-period, change duty while idle
        en = 1'b0;
        step_check("en_off", 0, 2'b00, 2'b00);
        start_write(ADDR_DUTY1, 32'd4);
        for (int i = 0; i < 8; i++) step_check("en_idle", i, 2'b00, 2'b00);

        // Restart from cnt 0; full-on, zero, small, boundary write-through, CTRL off
        en = 1'b1;
        for (int k = 1; k <= 115; k++) begin
            int c;
            int d;
            logic [1:0] e;
            c = (k - 1) % 10;
            if (k <= 20)       d = 4;
            else if (k <= 60)  d = 10;
            else if (k <= 80)  d = 0;
            else if (k <= 100) d = 2;
            else               d = 5;
            e = (c < d) ? 2'b01 : 2'b00;
            if (k >= 112) e = 2'b00;
            step_check("seq", k, e, 2'b00);
            if (k == 10)  start_write(ADDR_DUTY1, 32'd10);
            if (k == 30)  start_write(ADDR_DUTY1, 32'd15);
            if (k == 50)  start_write(ADDR_DUTY1, 32'd0);
            if (k == 70)  start_write(ADDR_DUTY1, 32'd2);
            if (k == 99)  start_write(ADDR_DUTY1, 32'd5);
            if (k == 110) start_write(ADDR_CTRL, 32'd0);
        end

        // Channel 2 reverse, then asynchronous reset mid-pulse
        en = 1'b0;
        start_write(ADDR_CTRL, 32'd2);
        step_check("ch2_setup", 0, 2'b00, 2'b00);
        start_write(ADDR_DUTY2, 32'hFFFF_FFFD);
        for (int i = 0; i < 8; i++) step_check("ch2_idle", i, 2'b00, 2'b00);
        en = 1'b1;
        for (int k = 1; k <= 2; k++) step_check("ch2", k, 2'b00, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pwm2", 0, {30'd0, pwm2out}, 32'd0);
        chk("async_rst_pwm1", 0, {30'd0, pwm1out}, 32'd0);
        chk("async_rst_rdata", 0, rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rd_check("post_rst_ctrl", ADDR_CTRL, 32'd0);
        rd_check("post_rst_period", ADDR_PERIOD, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
